// File: rtl/mix_columns_seq.sv
// -----------------------------------------------------------------------------
// mix_columns_seq
//   Forward AES MixColumns engine for the encryption datapath. A 128-bit state
//   is accepted over a valid/ready handshake and transformed one 32-bit column
//   per cycle through a single shared column-multiply datapath. The result is
//   held until downstream takes it. A per-transaction bypass flag (final AES
//   round) passes the state through unchanged with identical latency.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    in_state/in_bypass valid
//   in_ready   out  1    engine can accept (IDLE only)
//   in_state   in   128  input state, byte k = in_state[127-8k -: 8]
//   in_bypass  in   1    1 = return in_state unchanged
//   out_valid  out  1    out_state valid, held until accepted
//   out_ready  in   1    downstream accepts
//   out_state  out  128  result, same byte ordering as in_state
// -----------------------------------------------------------------------------
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q;
    logic [1:0]   col_q;
    logic         byp_q;
    logic [127:0] work_q;
    logic [127:0] work_d;
    logic         in_ready_q;
    logic         out_valid_q;

    logic [31:0]  col_sel;
    logic [31:0]  col_new;

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xt(input logic [7:0] a);
        xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; row 0 sits in the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        r0 = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
        r1 = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
        r2 = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
        r3 = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        mix_col = {r0, r1, r2, r3};
    endfunction

    // Shared column datapath: select column col_q, transform it, write it back.
    always_comb begin
        col_sel = 32'h0;
        case (col_q)
            2'd0: col_sel = work_q[127:96];
            2'd1: col_sel = work_q[95:64];
            2'd2: col_sel = work_q[63:32];
            2'd3: col_sel = work_q[31:0];
            default: col_sel = 32'h0;
        endcase

        col_new = byp_q ? col_sel : mix_col(col_sel);

        work_d = work_q;
        case (col_q)
            2'd0: work_d[127:96] = col_new;
            2'd1: work_d[95:64]  = col_new;
            2'd2: work_d[63:32]  = col_new;
            2'd3: work_d[31:0]   = col_new;
            default: work_d = work_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= 2'd0;
            byp_q       <= 1'b0;
            work_q      <= 128'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        work_q     <= in_state;
                        byp_q      <= in_bypass;
                        col_q      <= 2'd0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    work_q <= work_d;
                    // Counter wraps 3 -> 0 on the way into DONE.
                    col_q  <= col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_seq
//   Self-checking bench for mix_columns_seq: reset values, a table of known
//   vectors, randomized transactions against a matrix-form GF(2^8) reference,
//   backpressure and reset-during-BUSY sequences.
// -----------------------------------------------------------------------------
module tb_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int total;
    int bad;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] st;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [4];

    // Generic GF(2^8) multiply, shift-and-add form.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic       hi;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
        end
        return p;
    endfunction

    // Circulant MixColumns matrix: row r, column k -> 2,3,1,1 rotated.
    function automatic logic [7:0] coef(input int r, input int k);
        int d;
        d = (k - r + 4) % 4;
        if (d == 0) return 8'h02;
        if (d == 1) return 8'h03;
        return 8'h01;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] st, input logic byp);
        logic [127:0] res;
        logic [7:0]   acc;
        res = st;
        if (!byp) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++)
                        acc = acc ^ gmul(coef(r, k), st[127 - 8*(4*c + k) -: 8]);
                    res[127 - 8*(4*c + r) -: 8] = acc;
                end
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full transaction: accept, check 4-cycle latency and result, handshake out.
    task automatic run_txn(input string name, input logic [127:0] st,
                           input logic byp, input logic [127:0] exp);
        int lat;
        @(negedge clk);
        chk({name, ".ready_before"}, {127'h0, in_ready}, 128'h1);
        in_valid  = 1'b1;
        in_state  = st;
        in_bypass = byp;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
        in_state  = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = $urandom_range(0, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk({name, ".ready_busy"}, {127'h0, in_ready}, 128'h0);
            @(negedge clk);
            lat++;
        end
        chk({name, ".latency"}, 128'(lat), 128'd4);
        chk({name, ".result"}, out_state, exp);
        chk({name, ".ready_done"}, {127'h0, in_ready}, 128'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, ".valid_after"}, {127'h0, out_valid}, 128'h0);
        chk({name, ".ready_after"}, {127'h0, in_ready}, 128'h1);
        chk({name, ".hold_idle"}, out_state, exp);
    endtask

    initial begin
        logic [127:0] st;
        logic [127:0] held;
        logic         byp;
        int           n;

        total = 0;
        bad   = 0;

        vecs[0] = '{128'hdb135345f20a225c01010101c6c6c6c6, 1'b0,
                    128'h8e4da1bc9fdc589d01010101c6c6c6c6};
        vecs[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
                    128'h046681e5e0cb199a48f8d37a2806264c};
        vecs[2] = '{128'hd4d4d4d52d26314c00000000ffffffff, 1'b0,
                    128'hd5d5d7d64d7ebdf800000000ffffffff};
        vecs[3] = '{128'h0123456789abcdeffedcba9876543210, 1'b1,
                    128'h0123456789abcdeffedcba9876543210};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = 128'h0;
        in_bypass = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready",  {127'h0, in_ready},  128'h1);
        chk("reset.out_valid", {127'h0, out_valid}, 128'h0);
        chk("reset.out_state", out_state, 128'h0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].st, vecs[i].byp, vecs[i].exp);

        for (int i = 0; i < 20; i++) begin
            st  = {$urandom, $urandom, $urandom, $urandom};
            byp = ($urandom_range(0, 3) == 0);
            run_txn($sformatf("rand%0d", i), st, byp, ref_model(st, byp));
        end

        // Backpressure: hold DONE 10 cycles while input pins wiggle.
        @(negedge clk);
        st        = {$urandom, $urandom, $urandom, $urandom};
        in_valid  = 1'b1;
        in_state  = st;
        in_bypass = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp.latency", 128'(n), 128'd4);
        held = out_state;
        chk("bp.result", held, ref_model(st, 1'b0));
        for (int i = 0; i < 10; i++) begin
            in_valid  = $urandom_range(0, 1);
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            in_bypass = $urandom_range(0, 1);
            @(negedge clk);
            chk("bp.valid_held", {127'h0, out_valid}, 128'h1);
            chk("bp.state_held", out_state, held);
            chk("bp.ready_low",  {127'h0, in_ready},  128'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.valid_drop", {127'h0, out_valid}, 128'h0);
        chk("bp.ready_back", {127'h0, in_ready},  128'h1);
        repeat (3) begin
            @(negedge clk);
            chk("bp.single_xfer", {127'h0, out_valid}, 128'h0);
        end

        // Reset two cycles after an accept discards the transaction.
        @(negedge clk);
        in_valid  = 1'b1;
        in_state  = vecs[1].st;
        in_bypass = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstbusy.out_valid", {127'h0, out_valid}, 128'h0);
        chk("rstbusy.in_ready",  {127'h0, in_ready},  128'h1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("rstbusy.no_valid", 128'(n), 128'd0);
        run_txn("after_rst", vecs[2].st, 1'b0, vecs[2].exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

- Forward AES MixColumns engine for the encryption datapath, complementing the inverse-direction GF(2^8) constant-multiply tables used in decryption.
- Accepts a 128-bit state over a valid/ready handshake and transforms one 32-bit column per cycle over 4 cycles.
- Holds the result until the downstream round logic takes it.
- Supports a per-transaction bypass for the final AES round, which skips MixColumns.

## Interface
- No parameters.
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_state/in_bypass are valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_state  in  128  state; byte k = in_state[127-8k -: 8]; column c = bytes 4c..4c+3, with row 0 at the MSB.
- in_bypass  in  1  1 = pass the state through unchanged (final round).
- out_valid  out  1  out_state is valid; held until accepted.
- out_ready  in  1  downstream accepts.
- out_state  out  128  result, same byte ordering as in_state.

## Operation
- **States:**
  - IDLE: in_ready=1.
  - BUSY: 2-bit column counter col, 0..3.
  - DONE: out_valid=1.
- **IDLE:** on in_valid & in_ready, register in_state into the working register and in_bypass into a flag, clear col, go to BUSY.
- **BUSY:** each cycle, replace column col of the working register with MixColumns(column) (or leave it unchanged if the bypass flag is set), then increment col. After col=3 is processed, go to DONE.
- **DONE:** out_state = working register; out_valid=1. On out_ready, go to IDLE.
- **Per-column arithmetic:** input bytes a0..a3 (a0 = MSB byte), all ops mod 2^8, XOR only.
  - xt(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00); 3·a = xt(a)^a.
  - r0 = xt(a0)^3a1^a2^a3
  - r1 = a0^xt(a1)^3a2^a3
  - r2 = a0^a1^xt(a2)^3a3
  - r3 = 3a0^a1^a2^xt(a3)
- **Datapath:** exactly one column-multiply datapath is shared across the 4 cycles; the column is selected by col.
- **Input handling:** in_state and in_bypass are ignored outside an accept cycle. Changes on them while BUSY/DONE have no effect.
- **Output stability:** out_state changes only while BUSY. It is stable throughout DONE and remains at the last result in IDLE.

## Timing
- **Reset values:** state IDLE, in_ready=1, out_valid=0, out_state=128'h0, col=0, bypass flag=0.
- **Reset mid-operation** (BUSY or DONE): the transaction is discarded. out_valid=0 and in_ready=1 the cycle after the reset edge, with no output handshake.
- **Latency:** accept at edge E0; columns 0..3 are written at edges E1..E4; out_valid=1 from E4.
- **Bypass:** identical latency; the result equals in_state.
- **Throughput:** out_valid & out_ready at edge E5 gives IDLE, with in_ready=1 after E5. The next accept is at E6 at the earliest (one transaction per 6 cycles).
- **Backpressure:** with out_ready=0, DONE is held indefinitely with out_state constant. in_ready stays 0 for the whole of BUSY and DONE.
- **in_valid without in_ready:** no state change.
- **Wrap:** col wraps 3→0 on the transition to DONE.

## Test plan
- **Reset:** assert rst 2 cycles → in_ready=1, out_valid=0, out_state=0.
- **Single transaction:** in_state=db135345f20a225c01010101c6c6c6c6, bypass=0, out_ready=1 → out_valid rises 4 cycles after accept with out_state=8e4da1bc9fdc589d01010101c6c6c6c6. in_ready=0 from accept until the cycle after the output handshake.
- **FIPS-197 round 1:** in_state=d4bf5d30e0b452aeb84111f11e2798e5 → 046681e5e0cb199a48f8d37a2806264c.
  - Also in_state=d4d4d4d52d26314c00000000ffffffff → d5d5d7d64d7ebdf800000000ffffffff (covers xt reduction with a[7]=1).
- **Bypass:** in_state=0123456789abcdeffedcba9876543210, bypass=1 → the same value returned after 4 cycles.
- **Backpressure:** hold out_ready=0 for 10 cycles in DONE → out_valid=1 and out_state constant. Toggle in_valid/in_state meanwhile → no acceptance. Raise out_ready → exactly one transfer, then in_ready=1.
- **Reset mid-BUSY:** assert rst 2 cycles after accept → out_valid never rises. The next transaction completes with correct results and normal latency.
